// File: rtl/car_motion_ctrl.sv
// Frame-synchronous car motion controller: synchronized, debounced buttons drive an
// accelerate/cruise/brake FSM that moves car_x once per frame with wall clamping.
module car_motion_ctrl #(
  parameter int X_MAX        = 590,
  parameter int X_INIT       = 0,
  parameter int MAX_SPEED    = 4,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] car_x,
  output logic [2:0] speed,
  output logic       dir,
  output logic [1:0] state,
  output logic       wall_hit
);

  // state | meaning
  // IDLE  | stopped, waiting for an accepted command
  // RUN   | moving, accelerating while the command matches dir
  // BRAKE | moving, shedding one speed step per frame
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_BRAKE = 2'b10} state_t;
  typedef enum logic [1:0] {CMD_NONE = 2'b00, CMD_RIGHT = 2'b01, CMD_LEFT = 2'b10} cmd_t;

  localparam int CW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCEL_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [9:0]    X_MAX_C  = 10'(X_MAX);
  localparam logic [9:0]    X_INIT_C = 10'(X_INIT);
  localparam logic [2:0]    SPD_MAX  = 3'(MAX_SPEED);

  logic [1:0]    sync_l_q, sync_r_q;
  cmd_t          raw_cmd;
  cmd_t          prev_cmd_q, prev_cmd_d, cmd_q, cmd_d;
  state_t        state_q, state_d;
  logic [9:0]    car_x_q, car_x_d;
  logic [2:0]    speed_q, speed_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] accel_cnt_q, accel_cnt_d;
  logic          wall_hit_q, wall_hit_d;
  logic [10:0]   nx_right;
  logic          hit_right, hit_left, cmd_match;

  always_comb begin
    raw_cmd = CMD_NONE;
    case ({sync_l_q[1], sync_r_q[1]})
      2'b10:   raw_cmd = CMD_LEFT;
      2'b01:   raw_cmd = CMD_RIGHT;
      default: raw_cmd = CMD_NONE;
    endcase
  end

  assign nx_right  = {1'b0, car_x_q} + {8'b0, speed_q};
  assign hit_right = !dir_q && (nx_right >= {1'b0, X_MAX_C});
  assign hit_left  = dir_q && (car_x_q <= {7'b0, speed_q});
  assign cmd_match = dir_q ? (cmd_q == CMD_LEFT) : (cmd_q == CMD_RIGHT);

  always_comb begin
    prev_cmd_d  = prev_cmd_q;
    cmd_d       = cmd_q;
    state_d     = state_q;
    car_x_d     = car_x_q;
    speed_d     = speed_q;
    dir_d       = dir_q;
    accel_cnt_d = accel_cnt_q;
    wall_hit_d  = 1'b0;
    if (frame_tick) begin
      prev_cmd_d = raw_cmd;
      if (raw_cmd == prev_cmd_q) cmd_d = raw_cmd;
      // A wall clamp ends the move outright and takes priority over the FSM.
      if (state_q != S_IDLE && (hit_right || hit_left)) begin
        car_x_d    = dir_q ? 10'd0 : X_MAX_C;
        speed_d    = 3'd0;
        state_d    = S_IDLE;
        wall_hit_d = 1'b1;
      end else begin
        if (state_q != S_IDLE)
          car_x_d = dir_q ? (car_x_q - {7'b0, speed_q}) : nx_right[9:0];
        case (state_q)
          S_IDLE: begin
            if (cmd_q == CMD_RIGHT && car_x_q != X_MAX_C) begin
              state_d     = S_RUN;
              dir_d       = 1'b0;
              speed_d     = 3'd1;
              accel_cnt_d = '0;
            end else if (cmd_q == CMD_LEFT && car_x_q != 10'd0) begin
              state_d     = S_RUN;
              dir_d       = 1'b1;
              speed_d     = 3'd1;
              accel_cnt_d = '0;
            end
          end
          S_RUN: begin
            if (cmd_match) begin
              if (accel_cnt_q == CNT_LAST) begin
                accel_cnt_d = '0;
                if (speed_q < SPD_MAX) speed_d = speed_q + 3'd1;
              end else begin
                accel_cnt_d = accel_cnt_q + CNT_ONE;
              end
            end else begin
              state_d     = S_BRAKE;
              accel_cnt_d = '0;
            end
          end
          S_BRAKE: begin
            if (cmd_match) begin
              state_d     = S_RUN;
              accel_cnt_d = '0;
            end else if (speed_q <= 3'd1) begin
              speed_d = 3'd0;
              state_d = S_IDLE;
            end else begin
              speed_d = speed_q - 3'd1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_l_q    <= 2'b00;
      sync_r_q    <= 2'b00;
      prev_cmd_q  <= CMD_NONE;
      cmd_q       <= CMD_NONE;
      state_q     <= S_IDLE;
      car_x_q     <= X_INIT_C;
      speed_q     <= 3'd0;
      dir_q       <= 1'b0;
      accel_cnt_q <= '0;
      wall_hit_q  <= 1'b0;
    end else begin
      sync_l_q    <= {sync_l_q[0], btn_left};
      sync_r_q    <= {sync_r_q[0], btn_right};
      prev_cmd_q  <= prev_cmd_d;
      cmd_q       <= cmd_d;
      state_q     <= state_d;
      car_x_q     <= car_x_d;
      speed_q     <= speed_d;
      dir_q       <= dir_d;
      accel_cnt_q <= accel_cnt_d;
      wall_hit_q  <= wall_hit_d;
    end
  end

  assign car_x    = car_x_q;
  assign speed    = speed_q;
  assign dir      = dir_q;
  assign state    = state_q;
  assign wall_hit = wall_hit_q;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Bench for car_motion_ctrl: two instances (X_INIT 0 and 588) share stimulus and are
// checked against a frame-level reference model, plus a directed table and corner sequences.
module tb_car_motion_ctrl;
  localparam int XMAX = 590;
  localparam int MS   = 4;
  localparam int AF   = 8;

  logic clk = 1'b0;
  logic reset = 1'b0, frame_tick = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [9:0] car_x_a, car_x_b;
  logic [2:0] speed_a, speed_b;
  logic       dir_a, dir_b, wall_a, wall_b;
  logic [1:0] state_a, state_b;

  car_motion_ctrl #(.X_MAX(XMAX), .X_INIT(0), .MAX_SPEED(MS), .ACCEL_FRAMES(AF)) dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .car_x(car_x_a), .speed(speed_a), .dir(dir_a),
    .state(state_a), .wall_hit(wall_a));

  car_motion_ctrl #(.X_MAX(XMAX), .X_INIT(588), .MAX_SPEED(MS), .ACCEL_FRAMES(AF)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .car_x(car_x_b), .speed(speed_b), .dir(dir_b),
    .state(state_b), .wall_hit(wall_b));

  always #5 clk = ~clk;

  // st: 0 idle, 1 run, 2 brake; cmd: 0 none, 1 right, 2 left; dir: 0 right, 1 left
  typedef struct {int x; int spd; int dir; int st; int cnt; int prev; int cmdq; int wall; int xinit;} mdl_t;
  typedef struct {bit l; bit r; int x; int s; int st; int xb;} vec_t;

  mdl_t ma, mb;
  int n_vec = 0, n_miss = 0;

  function automatic mdl_t mdl_reset(mdl_t m);
    mdl_t n = m;
    n.x = m.xinit; n.spd = 0; n.dir = 0; n.st = 0; n.cnt = 0;
    n.prev = 0; n.cmdq = 0; n.wall = 0;
    return n;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int raw);
    mdl_t n = m;
    int c = m.cmdq;
    bit match, hit;
    hit = 0;
    n.wall = 0;
    n.prev = raw;
    if (raw == m.prev) n.cmdq = raw;
    match = (m.dir == 0 && c == 1) || (m.dir == 1 && c == 2);
    if (m.st != 0) begin
      if (m.dir == 0) begin
        if (m.x + m.spd >= XMAX) begin n.x = XMAX; hit = 1; end
        else n.x = m.x + m.spd;
      end else begin
        if (m.x <= m.spd) begin n.x = 0; hit = 1; end
        else n.x = m.x - m.spd;
      end
    end
    if (hit) begin
      n.spd = 0; n.st = 0; n.wall = 1;
      return n;
    end
    case (m.st)
      0: begin
        if ((c == 1 && m.x != XMAX) || (c == 2 && m.x != 0)) begin
          n.st = 1; n.dir = (c == 2) ? 1 : 0; n.spd = 1; n.cnt = 0;
        end
      end
      1: begin
        if (match) begin
          if (m.cnt == AF - 1) begin
            n.cnt = 0;
            n.spd = (m.spd + 1 > MS) ? MS : m.spd + 1;
          end else n.cnt = m.cnt + 1;
        end else begin
          n.st = 2; n.cnt = 0;
        end
      end
      default: begin
        if (match) begin
          n.st = 1; n.cnt = 0;
        end else begin
          n.spd = m.spd - 1;
          if (n.spd <= 0) begin n.spd = 0; n.st = 0; end
        end
      end
    endcase
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input bit after_tick);
    chk("a.car_x", int'(car_x_a), ma.x);
    chk("a.speed", int'(speed_a), ma.spd);
    chk("a.state", int'(state_a), ma.st);
    chk("a.wall_hit", int'(wall_a), after_tick ? ma.wall : 0);
    if (ma.spd != 0) chk("a.dir", int'(dir_a), ma.dir);
    chk("b.car_x", int'(car_x_b), mb.x);
    chk("b.speed", int'(speed_b), mb.spd);
    chk("b.state", int'(state_b), mb.st);
    chk("b.wall_hit", int'(wall_b), after_tick ? mb.wall : 0);
    if (mb.spd != 0) chk("b.dir", int'(dir_b), mb.dir);
  endtask

  // Buttons change just after an edge; gap >= 2 lets the synchronizer settle before the tick.
  task automatic frame(input bit l, input bit r, input int gap);
    int raw;
    btn_left = l;
    btn_right = r;
    repeat (gap) begin
      @(posedge clk); #1;
      check_all(1'b0);
    end
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    raw = (l && !r) ? 2 : (r && !l) ? 1 : 0;
    ma = mdl_step(ma, raw);
    mb = mdl_step(mb, raw);
    check_all(1'b1);
  endtask

  task automatic do_reset(input bit with_tick);
    @(negedge clk);
    reset = 1'b1;
    frame_tick = with_tick;
    @(posedge clk); #1;
    reset = 1'b0;
    frame_tick = 1'b0;
    ma = mdl_reset(ma);
    mb = mdl_reset(mb);
    check_all(1'b1);
  endtask

  initial begin
    vec_t tbl[29];
    int xb_ref;
    bit l, r;
    ma.xinit = 0;
    mb.xinit = 588;
    tbl[0]  = '{1'b0, 1'b1, 0, 0, 0, 588};
    tbl[1]  = '{1'b0, 1'b1, 0, 0, 0, 588};
    tbl[2]  = '{1'b0, 1'b1, 0, 1, 1, 588};
    tbl[3]  = '{1'b0, 1'b1, 1, 1, 1, 589};
    tbl[4]  = '{1'b0, 1'b1, 2, 1, 1, 590};
    tbl[5]  = '{1'b0, 1'b1, 3, 1, 1, 590};
    tbl[6]  = '{1'b0, 1'b1, 4, 1, 1, 590};
    tbl[7]  = '{1'b0, 1'b1, 5, 1, 1, 590};
    tbl[8]  = '{1'b0, 1'b1, 6, 1, 1, 590};
    tbl[9]  = '{1'b0, 1'b1, 7, 1, 1, 590};
    tbl[10] = '{1'b0, 1'b1, 8, 2, 1, 590};
    tbl[11] = '{1'b0, 1'b1, 10, 2, 1, 590};
    tbl[12] = '{1'b0, 1'b1, 12, 2, 1, 590};
    tbl[13] = '{1'b0, 1'b1, 14, 2, 1, 590};
    tbl[14] = '{1'b0, 1'b1, 16, 2, 1, 590};
    tbl[15] = '{1'b0, 1'b1, 18, 2, 1, 590};
    tbl[16] = '{1'b0, 1'b1, 20, 2, 1, 590};
    tbl[17] = '{1'b0, 1'b1, 22, 2, 1, 590};
    tbl[18] = '{1'b0, 1'b1, 24, 3, 1, 590};
    tbl[19] = '{1'b1, 1'b1, 27, 3, 1, 590};
    tbl[20] = '{1'b1, 1'b1, 30, 3, 1, 590};
    tbl[21] = '{1'b1, 1'b1, 33, 3, 2, 590};
    tbl[22] = '{1'b1, 1'b1, 36, 2, 2, 590};
    tbl[23] = '{1'b1, 1'b1, 38, 1, 2, 590};
    tbl[24] = '{1'b1, 1'b1, 39, 0, 0, 590};
    tbl[25] = '{1'b0, 1'b0, 39, 0, 0, 590};
    tbl[26] = '{1'b0, 1'b1, 39, 0, 0, 590};
    tbl[27] = '{1'b0, 1'b0, 39, 0, 0, 590};
    tbl[28] = '{1'b0, 1'b0, 39, 0, 0, 590};

    do_reset(1'b0);
    repeat (3) begin @(posedge clk); #1; check_all(1'b0); end

    for (int i = 0; i < 29; i++) begin
      frame(tbl[i].l, tbl[i].r, 3);
      chk($sformatf("tbl[%0d].car_x", i), int'(car_x_a), tbl[i].x);
      chk($sformatf("tbl[%0d].speed", i), int'(speed_a), tbl[i].s);
      chk($sformatf("tbl[%0d].state", i), int'(state_a), tbl[i].st);
      chk($sformatf("tbl[%0d].b_car_x", i), int'(car_x_b), tbl[i].xb);
      if (i == 4) chk("tbl.b_wall_hit", int'(wall_b), 1);
    end

    // Cruise right at speed 2, then reverse: brake bounded to +3, then run left.
    for (int k = 0; k < 30 && ma.spd != 2; k++) frame(1'b0, 1'b1, 3);
    chk("rev.speed2", int'(speed_a), 2);
    xb_ref = -1;
    for (int k = 0; k < 30; k++) begin
      frame(1'b1, 1'b0, 3);
      if (xb_ref >= 0 && ma.st == 2) chk("rev.brake_bound", int'(car_x_a <= 10'(xb_ref + 3)), 1);
      if (xb_ref < 0 && ma.st == 2) xb_ref = int'(car_x_a);
      if (ma.st == 1 && ma.dir == 1) break;
    end
    chk("rev.state", int'(state_a), 1);
    chk("rev.dir", int'(dir_a), 1);

    // Reset while running and during a frame tick.
    chk("rst.pre_nonzero", int'(car_x_a != 10'd0), 1);
    do_reset(1'b1);
    chk("rst.car_x", int'(car_x_a), 0);
    chk("rst.speed", int'(speed_a), 0);
    chk("rst.state", int'(state_a), 0);
    chk("rst.wall_hit", int'(wall_a), 0);
    chk("rst.b_car_x", int'(car_x_b), 588);

    // Long hold: speed saturates at MAX_SPEED.
    for (int k = 0; k < 50; k++) begin
      frame(1'b0, 1'b1, 2);
      chk("sat.le_max", int'(speed_a <= 3'd4), 1);
    end
    chk("sat.speed", int'(speed_a), 4);

    l = 1'b0;
    r = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          l = 1'($urandom_range(0, 1));
          r = 1'($urandom_range(0, 1));
        end
        frame(l, r, $urandom_range(2, 5));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
